fsm_step_arbiter: RTL
=====================

# fsm_step_arbiter

Sequencer and two-port arbiter for the 8-state, 4-bit Moore state-machine block. Two requesters ask for the machine to be moved to a target state; the arbiter grants one at a time, drives the machine's advance input with single-cycle pulses, watches the state feedback, and reports completion or error. It is the only driver of the machine's `data_in` in the design.

## Interface
- `MAX_STEPS`, default 8: pulse limit per request before error is flagged; one full lap of the 8-state ring.
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `req_a`  in  1: requester A level request; held until `done` is seen with `grant_a`.
- `tgt_a`  in  3: A's target state, s0..s7; must be stable while `req_a` is high.
- `req_b`  in  1: requester B level request; same rules as A.
- `tgt_b`  in  3: B's target state.
- `fsm_state`  in  4: current-state feedback from the state machine.
- `step_out`  out  1: drives the state machine's `data_in`; each high cycle advances it by one state.
- `grant_a`  out  1: high while A is being served.
- `grant_b`  out  1: high while B is being served.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid with `done`; 1 means the target was not reached.

## Operation
- Controller states: IDLE, GRANT, CHECK, STEP, DONE. All outputs are registered or decoded from state only (Moore); none depends combinationally on inputs.
- **IDLE:** outputs low.
  - If exactly one `req` is high, that requester wins.
  - If both are high, the winner is the requester not granted last. The `last` register resets to B, so A wins the first tie.
  - On a win: latch the winner's `tgt` into `target`, update `last`, clear `count`, go to GRANT.
- **GRANT:** the winner's grant goes high and stays high through DONE. Next state is CHECK.
- **CHECK:** evaluated in this order.
  - If `fsm_state[3]==1`: set err, go to DONE.
  - Else if `fsm_state[2:0]==target`: clear err, go to DONE.
  - Else if `count==MAX_STEPS`: set err, go to DONE.
  - Else go to STEP.
- **STEP:** `step_out=1` for exactly this cycle, `count` increments, next state is CHECK.
- **DONE:** `done=1` for one cycle, `err` holds the result, grant stays high. Next state is IDLE and the grant drops.
- The requester deasserts `req` on the edge where it sees `done`. The arbiter samples requests again only in IDLE.
- Ring order of the machine: s7 advances to s0. The number of pulses is therefore `(target - current) mod 8`, and wrap-around needs no special handling.
- A target equal to the current state issues zero pulses.
- `count` is 4 bits and saturates at `MAX_STEPS`.
- Changes to `tgt` or `req` of the granted requester during service are ignored, because `target` is latched.
- A request from the non-granted side is held off until IDLE; it is never dropped.
- **Reset mid-operation:** on the next edge, go to IDLE; all outputs 0, `count=0`, `last=B`. Any pulse in flight is cut, and `step_out` is never high in the cycle after reset. The state machine shares the reset and returns to s0.

## Timing
- Request high in IDLE at cycle T:
  - GRANT at T+1
  - first CHECK at T+2
  - DONE at T+3+2k, where k is the number of pulses issued
  - back in IDLE at T+4+2k
- Step period is 2 cycles. STEP drives `step_out`; the machine registers the advance on that edge, and the new state is visible in the following CHECK.
- Worst case for success (k=7): `done` at T+17.
- Error by lap limit (k=8): `done` with `err` at T+19.
- Minimum gap between back-to-back services is one IDLE cycle.

## Test plan
- **Basic advance:** after reset the machine is at s0. Set `req_a=1`, `tgt_a=3` at T. Required: `grant_a` from T+1; `step_out` high at T+3, T+5, T+7; `done=1`, `err=0` at T+9; `fsm_state=3`.
- **Wrap-around:** machine at s6, `req_b` with `tgt_b=1`. Required: exactly 3 pulses (s7, s0, s1); `done` at T+9 with `err=0`.
- **Zero steps:** machine at s5, `req_a` with `tgt_a=5`. Required: no `step_out` pulses; `done` at T+3.
- **Simultaneous requests and fairness:** `req_a` and `req_b` both high from reset. Required order of service: A, then B, then A. Each grant lasts through its `done`, and grants never overlap.
- **Error:** force `fsm_state=4'b1000` (or hold it stuck at s2) with target s4. Required: `done` with `err=1` at T+3 for the bit-3 case, and at T+19 after 8 pulses for the stuck case.
- **Reset mid-operation:** assert `reset` during the second STEP of a 5-step request. Required: on the next edge `busy`, `grant_a`, `step_out`, `done` and `err` are all 0 and the controller is in IDLE. After reset releases, a tie between A and B goes to A.

Source files
------------

// File: rtl/fsm_step_arbiter.sv
// fsm_step_arbiter: grants one of two requesters and pulses the 8-state ring machine to the granted target
module fsm_step_arbiter #(
    parameter int MAX_STEPS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic [2:0] tgt_a,
    input  logic       req_b,
    input  logic [2:0] tgt_b,
    input  logic [3:0] fsm_state,
    output logic       step_out,
    output logic       grant_a,
    output logic       grant_b,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, GRANT, CHECK, STEP, DONE} state_t;
    localparam logic [3:0] LIMIT = 4'(MAX_STEPS);
    state_t state, state_nx;
    logic [2:0] target;
    logic [3:0] count;
    logic last_b, own_b, err_q, pick_b, at_target, finish;
    always_comb begin
        pick_b    = req_b & (~req_a | ~last_b);
        at_target = fsm_state[2:0] == target;
        finish    = fsm_state[3] | at_target | (count == LIMIT);
    end
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = (req_a | req_b) ? GRANT : IDLE;
            GRANT:   state_nx = CHECK;
            CHECK:   state_nx = finish ? DONE : STEP;
            STEP:    state_nx = CHECK;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            target <= 3'd0;
            count  <= 4'd0;
            last_b <= 1'b1;
            own_b  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && (req_a | req_b)) begin
                target <= pick_b ? tgt_b : tgt_a;
                own_b  <= pick_b;
                last_b <= pick_b;
                count  <= 4'd0;
            end
            if (state == STEP && count != LIMIT)
                count <= count + 4'd1;
            if (state == CHECK)
                err_q <= fsm_state[3] | ~at_target;
        end
    end
    always_comb begin
        busy     = state != IDLE;
        step_out = state == STEP;
        done     = state == DONE;
        err      = done & err_q;
        grant_a  = busy & ~own_b;
        grant_b  = busy & own_b;
    end
endmodule
